// File: rtl/window_comp_invoke_fsm1_if.sv
// Scheduler / FIFO / level-2 FSM signal bundle for the window computation level-1 invoke controller.
// master drives requests, counts and level-2 done; slave is the controller itself.
interface window_comp_invoke_fsm1_if #(
  parameter int pop_width = 5
);
  logic                 invoke_in;
  logic [pop_width-1:0] pop_in_data;
  logic [pop_width-1:0] pop_in_length;
  logic [pop_width-1:0] pop_in_command;
  logic [pop_width-1:0] free_space_out;
  logic [1:0]           length_head;
  logic [1:0]           command_head;
  logic                 rd_in_length_fifo;
  logic                 rd_in_command_fifo;
  logic                 start_out;
  logic [1:0]           next_mode_out;
  logic                 done_in;
  logic [1:0]           length_out;
  logic [1:0]           command_out;
  logic                 enable_out;
  logic                 invoke_done_out;
  logic                 fired_out;
  logic [1:0]           mode_out;

  modport master (
    output invoke_in, pop_in_data, pop_in_length, pop_in_command, free_space_out,
           length_head, command_head, done_in,
    input  rd_in_length_fifo, rd_in_command_fifo, start_out, next_mode_out,
           length_out, command_out, enable_out, invoke_done_out, fired_out, mode_out
  );

  modport slave (
    input  invoke_in, pop_in_data, pop_in_length, pop_in_command, free_space_out,
           length_head, command_head, done_in,
    output rd_in_length_fifo, rd_in_command_fifo, start_out, next_mode_out,
           length_out, command_out, enable_out, invoke_done_out, fired_out, mode_out
  );
endinterface

// File: rtl/window_comp_invoke_fsm1.sv
// Level-1 invoke controller for the window computation actor: holds the CFDF mode,
// checks FIFO enables, latches length/command tokens and sequences the level-2 FSM.
//
// state  | meaning
// IDLE   | waiting for invoke_in
// CHECK  | evaluate enable for current mode
// LATCH  | pop length/command FIFOs and latch their heads
// START  | one-cycle start pulse to level-2 FSM
// WAIT   | wait for level-2 done_in
// UPDATE | advance CFDF mode
// DONE   | report completion and outcome
module window_comp_invoke_fsm1 #(
  parameter int size      = 3,
  parameter int width     = 10,
  parameter int pop_width = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  window_comp_invoke_fsm1_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LATCH, S_START, S_WAIT, S_UPDATE, S_DONE
  } state_t;

  localparam logic [1:0] M_SETUP  = 2'b00;
  localparam logic [1:0] M_COMP   = 2'b01;
  localparam logic [1:0] M_OUTPUT = 2'b10;

  if (size >= (1 << pop_width) || width < 1) begin : g_param_check
    $error("size must be representable in pop_width bits and width must be positive");
  end

  state_t     state;
  logic [1:0] mode;
  logic       fired_reg;
  logic       enable;

  // Illegal mode 11 falls into the default arm and is judged as SETUP_COMP.
  always_comb begin
    enable = 1'b0;
    case (mode)
      M_COMP:   enable = 1'b1;
      M_OUTPUT: enable = (bus.free_space_out != '0);
      default:  enable = (bus.pop_in_data >= pop_width'(size)) &&
                         (bus.pop_in_length != '0) && (bus.pop_in_command != '0);
    endcase
  end

  assign bus.enable_out    = enable;
  assign bus.mode_out      = mode;
  assign bus.next_mode_out = mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= S_IDLE;
      mode                   <= M_SETUP;
      fired_reg              <= 1'b0;
      bus.length_out         <= 2'b00;
      bus.command_out        <= 2'b00;
      bus.rd_in_length_fifo  <= 1'b0;
      bus.rd_in_command_fifo <= 1'b0;
      bus.start_out          <= 1'b0;
      bus.invoke_done_out    <= 1'b0;
      bus.fired_out          <= 1'b0;
    end else begin
      bus.rd_in_length_fifo  <= 1'b0;
      bus.rd_in_command_fifo <= 1'b0;
      bus.start_out          <= 1'b0;
      bus.invoke_done_out    <= 1'b0;
      bus.fired_out          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.invoke_in) state <= S_CHECK;
        end
        S_CHECK: begin
          if (!enable) begin
            state               <= S_DONE;
            fired_reg           <= 1'b0;
            bus.invoke_done_out <= 1'b1;
            bus.fired_out       <= 1'b0;
          end else if (mode == M_COMP || mode == M_OUTPUT) begin
            state         <= S_START;
            bus.start_out <= 1'b1;
          end else begin
            state                  <= S_LATCH;
            bus.rd_in_length_fifo  <= 1'b1;
            bus.rd_in_command_fifo <= 1'b1;
          end
        end
        S_LATCH: begin
          // Heads are first-word-fall-through, so they are valid while the pop strobe is high.
          bus.length_out  <= bus.length_head;
          bus.command_out <= bus.command_head;
          state           <= S_START;
          bus.start_out   <= 1'b1;
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.done_in) state <= S_UPDATE;
        end
        S_UPDATE: begin
          case (mode)
            M_SETUP: mode <= M_COMP;
            M_COMP:  mode <= M_OUTPUT;
            default: mode <= M_SETUP;
          endcase
          fired_reg           <= 1'b1;
          state               <= S_DONE;
          bus.invoke_done_out <= 1'b1;
          bus.fired_out       <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_window_comp_invoke_fsm1.sv
// Randomized bench for window_comp_invoke_fsm1 against a transaction-level model of
// the CFDF mode sequence, enable rules and invocation timing.
module tb_window_comp_invoke_fsm1;
  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_comp_invoke_fsm1_if #(.pop_width(PW)) bus ();

  window_comp_invoke_fsm1 #(.size(3), .width(10), .pop_width(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0/1/2 cycles SETUP_COMP -> COMP -> OUTPUT; latched tokens.
  int m_mode = 0;
  int m_len  = 0;
  int m_cmd  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.invoke_in      = 1'b0;
    bus.done_in        = 1'b0;
    bus.pop_in_data    = '0;
    bus.pop_in_length  = '0;
    bus.pop_in_command = '0;
    bus.free_space_out = '0;
    bus.length_head    = 2'b00;
    bus.command_head   = 2'b00;
  endtask

  // Cycle 0 is the cycle in which invoke_in is sampled in IDLE. Called just after a posedge.
  task automatic run_invoke(input int data, input int len, input int cmd, input int free,
                            input int lh, input int ch, input int d, input bit spur,
                            input bit cut);
    bit en, setup;
    int exp_start, exp_done, k;
    int n_rd_l, n_rd_c, rd_cyc, n_st, st_cyc, st_mode, n_dn, dn_cyc, dn_fired;
    bit was_cut;
    n_rd_l = 0; n_rd_c = 0; rd_cyc = -1; n_st = 0; st_cyc = -1; st_mode = -1;
    n_dn = 0; dn_cyc = -1; dn_fired = -1; was_cut = 1'b0;
    setup = (m_mode == 0);
    case (m_mode)
      0:       en = (data >= 3) && (len >= 1) && (cmd >= 1);
      1:       en = 1'b1;
      default: en = (free >= 1);
    endcase
    exp_start = 0;
    k = -10;
    if (!en) exp_done = 2;
    else begin
      exp_start = setup ? 3 : 2;
      k = exp_start + d;
      exp_done = k + 2;
    end
    for (int c = 0; c <= exp_done + 2; c++) begin
      bus.invoke_in = (c == 0) || (spur && c == 1) || (spur && en && c == exp_start + 1);
      bus.done_in   = (spur && c == 1) || (en && !cut && c == k);
      if (c < 2) begin
        bus.pop_in_data    = PW'(data);
        bus.pop_in_length  = PW'(len);
        bus.pop_in_command = PW'(cmd);
        bus.free_space_out = PW'(free);
      end else begin
        bus.pop_in_data    = '0;
        bus.pop_in_length  = '0;
        bus.pop_in_command = '0;
        bus.free_space_out = '0;
      end
      if (c <= 2) begin
        bus.length_head  = 2'(lh);
        bus.command_head = 2'(ch);
      end else begin
        bus.length_head  = 2'($urandom_range(0, 3));
        bus.command_head = 2'($urandom_range(0, 3));
      end
      if (cut && en && c == exp_start + 2) rst = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        check("enable_out", int'(bus.enable_out), int'(en));
        check("next_mode_idle", int'(bus.next_mode_out), m_mode);
      end
      if (bus.rd_in_length_fifo)  begin n_rd_l++; rd_cyc = c; end
      if (bus.rd_in_command_fifo) n_rd_c++;
      if (bus.start_out) begin n_st++; st_cyc = c; st_mode = int'(bus.next_mode_out); end
      if (bus.invoke_done_out) begin n_dn++; dn_cyc = c; dn_fired = int'(bus.fired_out); end
      if (cut && en && c == exp_start + 2) begin
        was_cut = 1'b1;
        check("rst_mode", int'(bus.mode_out), 0);
        check("rst_length", int'(bus.length_out), 0);
        check("rst_command", int'(bus.command_out), 0);
        check("rst_no_done", n_dn, 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (was_cut) begin
      m_mode = 0; m_len = 0; m_cmd = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive_idle();
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus.invoke_done_out || bus.start_out) n_dn++;
        @(posedge clk);
        #1;
      end
      check("rst_quiet", n_dn, 0);
      check("rst_mode_after", int'(bus.mode_out), 0);
      return;
    end
    check("done_cnt", n_dn, 1);
    check("done_cyc", dn_cyc, exp_done);
    check("fired", dn_fired, int'(en));
    check("rd_len_cnt", n_rd_l, int'(en && setup));
    check("rd_cmd_cnt", n_rd_c, int'(en && setup));
    check("start_cnt", n_st, int'(en));
    if (en && setup) check("rd_cyc", rd_cyc, 2);
    if (en) begin
      check("start_cyc", st_cyc, exp_start);
      check("start_mode", st_mode, m_mode);
      if (setup) begin
        m_len = lh;
        m_cmd = ch;
      end
      m_mode = (m_mode + 1) % 3;
    end
    check("length_out", int'(bus.length_out), m_len);
    check("command_out", int'(bus.command_out), m_cmd);
    check("mode_out", int'(bus.mode_out), m_mode);
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mode", int'(bus.mode_out), 0);
    check("reset_length", int'(bus.length_out), 0);
    check("reset_command", int'(bus.command_out), 0);
    check("reset_rd", int'(bus.rd_in_length_fifo) + int'(bus.rd_in_command_fifo), 0);
    check("reset_start", int'(bus.start_out), 0);
    check("reset_done", int'(bus.invoke_done_out) + int'(bus.fired_out), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_invoke(3, 1, 1, 0, 2, 1, 5, 1'b0, 1'b0);  // SETUP_COMP fires
    run_invoke(0, 0, 0, 0, 3, 3, 2, 1'b0, 1'b0);  // COMP with empty FIFOs
    run_invoke(9, 9, 9, 0, 0, 0, 1, 1'b0, 1'b0);  // OUTPUT rejected, no space
    run_invoke(0, 0, 0, 1, 0, 0, 1, 1'b0, 1'b0);  // OUTPUT fires at one slot
    run_invoke(2, 1, 1, 5, 1, 1, 1, 1'b0, 1'b0);  // one data token short
    run_invoke(3, 1, 0, 5, 1, 1, 1, 1'b0, 1'b0);  // no command token
    run_invoke(3, 2, 2, 0, 3, 2, 4, 1'b1, 1'b0);  // spurious invoke/done
    run_invoke(3, 1, 1, 0, 1, 3, 9, 1'b0, 1'b1);  // reset while waiting
    run_invoke(3, 1, 1, 0, 2, 1, 5, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_invoke($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/window_comp_invoke_fsm1.md
Name: window_comp_invoke_fsm1

Overview:
- Level-1 invoke controller for the window computation actor. Sits directly upstream of the level-2 firing-state FSM.
- Holds the actor's CFDF mode (SETUP_COMP, COMP, OUTPUT) and checks per-mode FIFO enable conditions.
- Pops and latches the length/command tokens, then starts and waits on the level-2 FSM for each firing.
- Reports each invocation's completion and outcome to the scheduler.

Parameters:
- size, 3, tokens per input vector (data tokens consumed by SETUP_COMP)
- width, 10, data bit width (no datapath here; passed through for consistency)
- pop_width, 5, bit width of FIFO population / free-space counts

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- invoke_in  in  1  scheduler request to attempt one firing
- pop_in_data  in  pop_width  token count in data input FIFO
- pop_in_length  in  pop_width  token count in length FIFO
- pop_in_command  in  pop_width  token count in command FIFO
- free_space_out  in  pop_width  free slots in output FIFO
- length_head  in  2  head of length FIFO (first-word-fall-through)
- command_head  in  2  head of command FIFO (FWFT)
- rd_in_length_fifo  out  1  pop strobe, length FIFO
- rd_in_command_fifo  out  1  pop strobe, command FIFO
- start_out  out  1  start pulse to level-2 FSM start_in
- next_mode_out  out  2  mode to level-2 FSM next_mode_in
- done_in  in  1  level-2 FSM done_out
- length_out  out  2  latched length for level-2 FSM
- command_out  out  2  latched command for level-2 FSM
- enable_out  out  1  combinational: current mode is fireable
- invoke_done_out  out  1  one-cycle pulse, invocation finished
- fired_out  out  1  valid with invoke_done_out: 1 = fired, 0 = rejected
- mode_out  out  2  current CFDF mode register

Behaviour:
- Mode encoding: SETUP_COMP = 00, COMP = 01, OUTPUT = 10. The value 11 is illegal; it is treated as SETUP_COMP and rewritten to 00 on the next UPDATE.
- Enable rules (enable_out is combinational from mode and counts):
  - SETUP_COMP: pop_in_data >= size AND pop_in_length >= 1 AND pop_in_command >= 1.
  - COMP: always 1.
  - OUTPUT: free_space_out >= 1.
  - Comparisons are unsigned; equality enables.
- States: IDLE, CHECK, LATCH, START, WAIT, UPDATE, DONE.
  - IDLE: if invoke_in = 1, go to CHECK; otherwise stay.
  - CHECK: if enable_out = 0, go to DONE with fired_reg <= 0. If enabled and mode = SETUP_COMP, go to LATCH. If enabled and any other mode, go to START.
  - LATCH: rd_in_length_fifo = rd_in_command_fifo = 1 for exactly one cycle; length_out <= length_head and command_out <= command_head on the same edge. Go to START.
  - START: start_out = 1 for one cycle, next_mode_out = mode. Go to WAIT.
  - WAIT: hold until done_in = 1, then go to UPDATE. No timeout.
  - UPDATE: mode advances SETUP_COMP -> COMP -> OUTPUT -> SETUP_COMP; fired_reg <= 1. Go to DONE.
  - DONE: invoke_done_out = 1 and fired_out = fired_reg for one cycle. Go to IDLE.
- next_mode_out equals mode at all times. start_out is 0 outside START.
- length_out and command_out hold their values until the next LATCH, so they stay stable across the COMP firing.
- Latency from invoke_in sampled in IDLE (cycle 0) to invoke_done_out:
  - Rejected firing: cycle 2.
  - SETUP_COMP firing: done_in at cycle k gives invoke_done_out at cycle k+2, with k >= 4.
  - COMP or OUTPUT firing: same k+2 rule, with k >= 3.
- invoke_in is ignored in every state except IDLE, and is not queued. done_in is ignored outside WAIT.
- Enable is evaluated only in CHECK. Count changes after CHECK do not abort a firing.
- Reset values: state = IDLE, mode = SETUP_COMP, length_out = 0, command_out = 0, fired_reg = 0. All strobes/pulses (rd_*, start_out, invoke_done_out, fired_out) = 0.
- Reset mid-firing: immediate return to reset values. No done pulse is issued, and the same rst resets the level-2 FSM.

Test Plan:
1. Reset, then counts data = 3, length = 1, command = 1, heads length = 2, command = 1; pulse invoke_in; level-2 model returns done_in 5 cycles after start → rd strobes once in LATCH; length_out = 2, command_out = 1; start_out one cycle with next_mode_out = 00; invoke_done_out with fired_out = 1; mode_out = 01.
2. Mode COMP with all counts 0; invoke → fires, start_out with next_mode_out = 01, no rd strobes, length_out/command_out unchanged, mode_out = 10.
3. Mode OUTPUT, free_space_out = 0; invoke → invoke_done_out at cycle 2 with fired_out = 0, no start_out, mode stays 10. Repeat with free_space_out = 1 → fires, mode returns to 00.
4. Mode SETUP_COMP, pop_in_data = 2 (size − 1) → rejected. pop_in_data = 3 with pop_in_command = 0 → rejected. No rd strobes in either case.
5. During WAIT: pulse invoke_in and assert a spurious done_in → invoke_in is ignored; done_in completes the firing exactly once with a single invoke_done_out pulse.
6. Assert rst low while in WAIT → mode_out = 00, length_out = 0, no invoke_done_out. A subsequent invoke behaves as in scenario 1.
